// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one external 8-bit async SRAM between two req/ack requesters
//   (port A: CPU memory cycles, port B: loader / DMA). Each granted access
//   runs IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> HOLD -> IDLE with all
//   SRAM pins and acks driven from registers.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (level, held until a_ack)
//   a_ack, a_rdata              port A completion pulse, read data
//   b_*                         same as port A, for port B
//   sram_addr/sram_dout/sram_doe  SRAM address, write data, pad drive enable
//   sram_din                    data sampled from the SRAM bus
//   n_sram_ce/oe/we             active-low SRAM strobes
//   owner                       port of current/last grant (0=A, 1=B)
module sram_port_arbiter #(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned ADDR_W        = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wdata,
  output logic              a_ack,
  output logic [7:0]        a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wdata,
  output logic              b_ack,
  output logic [7:0]        b_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  output logic              sram_doe,
  input  logic [7:0]        sram_din,
  output logic              n_sram_ce,
  output logic              n_sram_oe,
  output logic              n_sram_we,
  output logic              owner
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t r_state, w_state_nx;
  logic [3:0] r_cnt, w_cnt_nx;
  logic r_we, w_we_nx;

  logic              w_grant_b;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [7:0]        w_dout_nx, w_a_rdata_nx, w_b_rdata_nx;
  logic              w_doe_nx, w_ce_nx, w_oe_nx, w_wen_nx, w_owner_nx;
  logic              w_a_ack_nx, w_b_ack_nx;

  // Sole requester wins; on a tie the port opposite to the last grant wins.
  assign w_grant_b = b_req & (~a_req | ~owner);

  // Output registers are loaded with the values belonging to the state being
  // entered, so every pin changes on the same edge as the state transition.
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_we_nx      = r_we;
    w_addr_nx    = sram_addr;
    w_dout_nx    = sram_dout;
    w_owner_nx   = owner;
    w_a_rdata_nx = a_rdata;
    w_b_rdata_nx = b_rdata;
    w_doe_nx     = 1'b0;
    w_ce_nx      = 1'b1;
    w_oe_nx      = 1'b1;
    w_wen_nx     = 1'b1;
    w_a_ack_nx   = 1'b0;
    w_b_ack_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (a_req | b_req) begin
          w_state_nx = S_SETUP;
          w_owner_nx = w_grant_b;
          w_we_nx    = w_grant_b ? b_we : a_we;
          w_addr_nx  = w_grant_b ? b_addr : a_addr;
          w_ce_nx    = 1'b0;
          if (w_we_nx) begin
            w_doe_nx  = 1'b1;
            w_dout_nx = w_grant_b ? b_wdata : a_wdata;
          end else begin
            w_oe_nx = 1'b0;
          end
        end
      end
      S_SETUP: begin
        w_state_nx = S_STROBE;
        w_cnt_nx   = 4'(STROBE_CYCLES - 1);
        w_ce_nx    = 1'b0;
        w_doe_nx   = r_we;
        w_wen_nx   = ~r_we;
        w_oe_nx    = r_we;
      end
      S_STROBE: begin
        w_ce_nx = 1'b0;
        w_doe_nx = r_we;
        if (r_cnt == 4'd0) begin
          // Edge ending the last strobe cycle: release strobes, capture, ack.
          w_state_nx = S_HOLD;
          w_a_ack_nx = ~owner;
          w_b_ack_nx = owner;
          if (!r_we) begin
            if (owner) w_b_rdata_nx = sram_din;
            else       w_a_rdata_nx = sram_din;
          end
        end else begin
          w_cnt_nx = r_cnt - 4'd1;
          w_wen_nx = ~r_we;
          w_oe_nx  = r_we;
        end
      end
      S_HOLD: begin
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      sram_addr <= '0;
      sram_dout <= '0;
      sram_doe  <= 1'b0;
      n_sram_ce <= 1'b1;
      n_sram_oe <= 1'b1;
      n_sram_we <= 1'b1;
      owner     <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_we      <= w_we_nx;
      sram_addr <= w_addr_nx;
      sram_dout <= w_dout_nx;
      sram_doe  <= w_doe_nx;
      n_sram_ce <= w_ce_nx;
      n_sram_oe <= w_oe_nx;
      n_sram_we <= w_wen_nx;
      owner     <= w_owner_nx;
      a_ack     <= w_a_ack_nx;
      b_ack     <= w_b_ack_nx;
      a_rdata   <= w_a_rdata_nx;
      b_rdata   <= w_b_rdata_nx;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: instance dut uses STROBE_CYCLES=2, dut1 uses STROBE_CYCLES=1.
module tb_sram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // STROBE_CYCLES=2 instance
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [17:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_wdata = '0, b_wdata = '0, sram_din = '0;
  logic a_ack, b_ack, sram_doe, n_sram_ce, n_sram_oe, n_sram_we, owner;
  logic [7:0] a_rdata, b_rdata, sram_dout;
  logic [17:0] sram_addr;

  // STROBE_CYCLES=1 instance
  logic a_req1 = 0, a_we1 = 0;
  logic [17:0] a_addr1 = '0;
  logic [7:0] a_wdata1 = '0, sram_din1 = '0;
  logic a_ack1, b_ack1, sram_doe1, n_sram_ce1, n_sram_oe1, n_sram_we1, owner1;
  logic [7:0] a_rdata1, b_rdata1, sram_dout1;
  logic [17:0] sram_addr1;

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter #(.STROBE_CYCLES(2), .ADDR_W(18)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_doe(sram_doe),
    .sram_din(sram_din), .n_sram_ce(n_sram_ce), .n_sram_oe(n_sram_oe),
    .n_sram_we(n_sram_we), .owner(owner)
  );

  sram_port_arbiter #(.STROBE_CYCLES(1), .ADDR_W(18)) dut1 (
    .clk(clk), .reset(reset),
    .a_req(a_req1), .a_we(a_we1), .a_addr(a_addr1), .a_wdata(a_wdata1),
    .a_ack(a_ack1), .a_rdata(a_rdata1),
    .b_req(1'b0), .b_we(1'b0), .b_addr(18'h0), .b_wdata(8'h00),
    .b_ack(b_ack1), .b_rdata(b_rdata1),
    .sram_addr(sram_addr1), .sram_dout(sram_dout1), .sram_doe(sram_doe1),
    .sram_din(sram_din1), .n_sram_ce(n_sram_ce1), .n_sram_oe(n_sram_oe1),
    .n_sram_we(n_sram_we1), .owner(owner1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Per-cycle pin rules on the STROBE_CYCLES=2 instance.
  task automatic check_rules();
    check("doe_with_oe", {31'd0, sram_doe & ~n_sram_oe}, 0);
    check("we_and_oe_low", {31'd0, ~n_sram_we & ~n_sram_oe}, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acks, ack_at, lo_cnt, doe_cnt, other;
    int ack_idx [4];
    int ack_port[4];
    int ack_own [4];
    int exp_port[4] = '{0, 1, 0, 1};
    int exp_idx [4] = '{4, 9, 14, 19};

    // ---------------- reset values ----------------
    step(); step();
    check("rst_ce", n_sram_ce, 1);
    check("rst_oe", n_sram_oe, 1);
    check("rst_we", n_sram_we, 1);
    check("rst_doe", sram_doe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dout", sram_dout, 0);
    check("rst_acks", {a_ack, b_ack}, 0);
    check("rst_rdata", {a_rdata, b_rdata}, 0);
    check("rst_owner", owner, 1);
    reset = 1'b0;

    // ---------------- T1: A read ----------------
    step();
    a_req = 1; a_we = 0; a_addr = 18'h00100; sram_din = 8'h3C;
    acks = 0; ack_at = 0; lo_cnt = 0; other = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_rules();
      if (i == 1) begin
        check("t1_addr", sram_addr, 18'h00100);
        check("t1_ce", n_sram_ce, 0);
        check("t1_owner", owner, 0);
      end
      if (!n_sram_oe) lo_cnt++;
      if (b_ack) other++;
      if (a_ack) begin
        acks++; ack_at = i;
        check("t1_rdata", a_rdata, 8'h3C);
        a_req = 0; sram_din = 8'hFF;
      end
    end
    check("t1_oe_cycles", lo_cnt, 3);
    check("t1_ack_cnt", acks, 1);
    check("t1_ack_at", ack_at, 4);
    check("t1_b_ack", other, 0);
    check("t1_rdata_held", a_rdata, 8'h3C);
    check("t1_idle_ce", n_sram_ce, 1);

    // ---------------- T2: B write ----------------
    b_req = 1; b_we = 1; b_addr = 18'h2ABCD; b_wdata = 8'hA5;
    acks = 0; ack_at = 0; lo_cnt = 0; doe_cnt = 0; other = 0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_rules();
      if (i == 1) begin
        check("t2_addr", sram_addr, 18'h2ABCD);
        check("t2_dout", sram_dout, 8'hA5);
        check("t2_setup_we", n_sram_we, 1);
      end
      if (!n_sram_we) lo_cnt++;
      if (sram_doe) doe_cnt++;
      if (a_ack) other++;
      if (b_ack) begin
        acks++; ack_at = i;
        check("t2_hold_addr", sram_addr, 18'h2ABCD);
        check("t2_hold_doe", sram_doe, 1);
        b_req = 0;
      end
    end
    check("t2_we_cycles", lo_cnt, 2);
    check("t2_doe_cycles", doe_cnt, 4);
    check("t2_ack_cnt", acks, 1);
    check("t2_ack_at", ack_at, 4);
    check("t2_a_ack", other, 0);
    check("t2_owner", owner, 1);
    check("t2_a_rdata_kept", a_rdata, 8'h3C);

    // ---------------- T3: both requesting from reset ----------------
    do_reset();
    a_req = 1; a_we = 0; a_addr = 18'h00011;
    b_req = 1; b_we = 0; b_addr = 18'h00022;
    sram_din = 8'h5A;
    acks = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      check_rules();
      check("t3_dual_ack", {31'd0, a_ack & b_ack}, 0);
      if ((a_ack | b_ack) && acks < 4) begin
        ack_idx[acks] = i;
        ack_port[acks] = b_ack ? 1 : 0;
        ack_own[acks] = owner ? 1 : 0;
        acks++;
        if (acks == 4) begin a_req = 0; b_req = 0; end
      end
    end
    check("t3_ack_cnt", acks, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < acks) begin
        check($sformatf("t3_port%0d", k), ack_port[k], exp_port[k]);
        check($sformatf("t3_owner%0d", k), ack_own[k], exp_port[k]);
        check($sformatf("t3_idx%0d", k), ack_idx[k], exp_idx[k]);
      end
    end

    // ---------------- T4: reset during write STROBE ----------------
    a_req = 1; a_we = 1; a_addr = 18'h00001; a_wdata = 8'h11;
    step();                        // SETUP
    step();                        // first STROBE cycle
    check("t4_in_strobe", n_sram_we, 0);
    reset = 1'b1;
    step();
    check("t4_rst_we", n_sram_we, 1);
    check("t4_rst_ce", n_sram_ce, 1);
    check("t4_rst_doe", sram_doe, 0);
    check("t4_rst_ack", a_ack, 0);
    reset = 1'b0;
    acks = 0; ack_at = 0; lo_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check_rules();
      if (!n_sram_we) lo_cnt++;
      if (a_ack) begin
        acks++; ack_at = i; a_req = 0;
        check("t4_addr", sram_addr, 18'h00001);
        check("t4_dout", sram_dout, 8'h11);
      end
    end
    check("t4_ack_cnt", acks, 1);
    check("t4_ack_at", ack_at, 4);
    check("t4_we_cycles", lo_cnt, 2);

    // ---------------- T6: req dropped after grant ----------------
    a_req = 1; a_we = 0; a_addr = 18'h3FFFF; sram_din = 8'hC3;
    step();
    a_req = 0; a_addr = 18'h00000;
    acks = 0; ack_at = 0;
    for (int i = 2; i <= 8; i++) begin
      step();
      check_rules();
      if (a_ack) begin
        acks++; ack_at = i;
        check("t6_addr", sram_addr, 18'h3FFFF);
        check("t6_rdata", a_rdata, 8'hC3);
      end
      if (i >= 5)
        check($sformatf("t6_idle%0d", i),
              {28'd0, n_sram_ce, n_sram_oe, n_sram_we, sram_doe}, 4'b1110);
    end
    check("t6_ack_cnt", acks, 1);
    check("t6_ack_at", ack_at, 4);

    // ---------------- T5: STROBE_CYCLES=1, read then write ----------------
    a_req1 = 1; a_we1 = 0; a_addr1 = 18'h00005; sram_din1 = 8'h77;
    acks = 0; lo_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("t5_doe_with_oe", {31'd0, sram_doe1 & ~n_sram_oe1}, 0);
      if (!n_sram_we1) lo_cnt++;
      if (a_ack1 && acks < 2) begin
        ack_idx[acks] = i;
        acks++;
        if (acks == 1) begin
          check("t5_rdata", a_rdata1, 8'h77);
          a_we1 = 1; a_wdata1 = 8'h99; a_addr1 = 18'h00006;
        end else begin
          check("t5_dout", sram_dout1, 8'h99);
          check("t5_addr", sram_addr1, 18'h00006);
          check("t5_doe", sram_doe1, 1);
          a_req1 = 0;
        end
      end
    end
    check("t5_ack_cnt", acks, 2);
    if (acks == 2) begin
      check("t5_ack0", ack_idx[0], 3);
      check("t5_ack1", ack_idx[1], 7);
    end
    check("t5_we_cycles", lo_cnt, 1);
    check("t5_rdata_held", a_rdata1, 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
